// File: rtl/neureka_tcdm_split_realign.sv
// Splits a wide TCDM request into MP 32-bit port transactions and realigns read responses.
// Optional NEUREKA_TCDM_SPLIT_BE_SKIP_EN: write ports with all-zero byte enables are not requested.
module neureka_tcdm_split_realign #(
  parameter int unsigned BW    = 128,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   w_req_i,
  output logic                   w_gnt_o,
  input  logic [31:0]            w_add_i,
  input  logic                   w_wen_i,
  input  logic [BW/8-1:0]        w_be_i,
  input  logic [BW-1:0]          w_data_i,
  output logic [BW-1:0]          w_r_data_o,
  output logic                   w_r_valid_o,
  output logic [BW/32-1:0]       tcdm_req_o,
  input  logic [BW/32-1:0]       tcdm_gnt_i,
  output logic [BW/32*32-1:0]    tcdm_add_o,
  output logic [BW/32-1:0]       tcdm_wen_o,
  output logic [BW/32*4-1:0]     tcdm_be_o,
  output logic [BW/32*32-1:0]    tcdm_data_o,
  input  logic [BW/32*32-1:0]    tcdm_r_data_i,
  input  logic [BW/32-1:0]       tcdm_r_valid_i,
  output logic                   err_o
);
  localparam int unsigned MP = BW / 32;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [MP-1:0] done_q, done_d;
  logic [MP-1:0] grant, credit_ok, skip, resp_ok, stray, nonempty;
  logic          err_q, err_d;
  logic [CW-1:0] pend_q [MP];
  logic [CW-1:0] pend_d [MP];
  logic [CW-1:0] occ_q  [MP];
  logic [CW-1:0] occ_d  [MP];
  logic [PW-1:0] wptr_q [MP];
  logic [PW-1:0] wptr_d [MP];
  logic [PW-1:0] rptr_q [MP];
  logic [PW-1:0] rptr_d [MP];
  logic [31:0]   mem_q  [MP][DEPTH];

  // Port mapping, request gating and response classification.
  always_comb begin
    tcdm_req_o  = '0;
    tcdm_add_o  = '0;
    tcdm_wen_o  = '0;
    tcdm_be_o   = '0;
    tcdm_data_o = '0;
    w_r_data_o  = '0;
    grant       = '0;
    credit_ok   = '0;
    skip        = '0;
    resp_ok     = '0;
    stray       = '0;
    nonempty    = '0;
    for (int ii = 0; ii < MP; ii++) begin
      tcdm_add_o[32*ii+:32]  = w_add_i + 32'(4 * ii);
      tcdm_wen_o[ii]         = w_wen_i;
      tcdm_be_o[4*ii+:4]     = w_be_i[4*ii+:4];
      tcdm_data_o[32*ii+:32] = w_data_i[32*ii+:32];
`ifdef NEUREKA_TCDM_SPLIT_BE_SKIP_EN
      skip[ii] = ~w_wen_i & (w_be_i[4*ii+:4] == 4'b0000);
`else
      skip[ii] = 1'b0;
`endif
      // A read may only go out if its response is guaranteed a FIFO slot.
      credit_ok[ii] = ~w_wen_i |
                      (({1'b0, occ_q[ii]} + {1'b0, pend_q[ii]}) < (CW + 1)'(DEPTH));
      tcdm_req_o[ii] = w_req_i & ~done_q[ii] & credit_ok[ii] & ~skip[ii];
      grant[ii]      = tcdm_req_o[ii] & tcdm_gnt_i[ii];
      resp_ok[ii]    = tcdm_r_valid_i[ii] & (pend_q[ii] != '0);
      stray[ii]      = tcdm_r_valid_i[ii] & (pend_q[ii] == '0);
      nonempty[ii]   = (occ_q[ii] != '0);
    end
    for (int ii = 0; ii < MP; ii++) begin
      w_r_data_o[32*ii+:32] = (&nonempty) ? mem_q[ii][rptr_q[ii]] : 32'h0;
    end
  end

  assign w_gnt_o     = w_req_i & (&(done_q | grant | skip));
  assign w_r_valid_o = &nonempty;
  assign err_o       = err_q;

  always_comb begin
    done_d = done_q;
    err_d  = err_q | (|stray);
    if (w_gnt_o) done_d = '0;
    else if (w_req_i) done_d = done_q | grant;
    for (int ii = 0; ii < MP; ii++) begin
      pend_d[ii] = pend_q[ii];
      occ_d[ii]  = occ_q[ii];
      wptr_d[ii] = wptr_q[ii];
      rptr_d[ii] = rptr_q[ii];
      if (grant[ii] & w_wen_i & ~resp_ok[ii]) pend_d[ii] = pend_q[ii] + CW'(1);
      else if (~(grant[ii] & w_wen_i) & resp_ok[ii]) pend_d[ii] = pend_q[ii] - CW'(1);
      if (resp_ok[ii]) wptr_d[ii] = (wptr_q[ii] == PW'(DEPTH - 1)) ? '0 : wptr_q[ii] + PW'(1);
      if (w_r_valid_o) rptr_d[ii] = (rptr_q[ii] == PW'(DEPTH - 1)) ? '0 : rptr_q[ii] + PW'(1);
      if (resp_ok[ii] & ~w_r_valid_o) occ_d[ii] = occ_q[ii] + CW'(1);
      else if (~resp_ok[ii] & w_r_valid_o) occ_d[ii] = occ_q[ii] - CW'(1);
    end
    if (clear_i) begin
      done_d = '0;
      err_d  = 1'b0;
      for (int ii = 0; ii < MP; ii++) begin
        pend_d[ii] = '0;
        occ_d[ii]  = '0;
        wptr_d[ii] = '0;
        rptr_d[ii] = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q <= '0;
      err_q  <= 1'b0;
      for (int ii = 0; ii < MP; ii++) begin
        pend_q[ii] <= '0;
        occ_q[ii]  <= '0;
        wptr_q[ii] <= '0;
        rptr_q[ii] <= '0;
      end
    end else begin
      done_q <= done_d;
      err_q  <= err_d;
      for (int ii = 0; ii < MP; ii++) begin
        pend_q[ii] <= pend_d[ii];
        occ_q[ii]  <= occ_d[ii];
        wptr_q[ii] <= wptr_d[ii];
        rptr_q[ii] <= rptr_d[ii];
      end
    end
  end

  // FIFO storage needs no reset: heads are masked until every FIFO holds data.
  always_ff @(posedge clk_i) begin
    for (int ii = 0; ii < MP; ii++) begin
      if (resp_ok[ii] & ~clear_i) mem_q[ii][wptr_q[ii]] <= tcdm_r_data_i[32*ii+:32];
    end
  end

endmodule

// File: tb/tb_neureka_tcdm_split_realign.sv
// Bench for neureka_tcdm_split_realign (BW=128, MP=4, DEPTH=2): directed scenarios plus randomized traffic.
module tb_neureka_tcdm_split_realign;
  localparam int BW = 128;
  localparam int MP = 4;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n, clear;
  logic w_req, w_gnt, w_wen, w_r_valid, err;
  logic [31:0] w_add;
  logic [15:0] w_be;
  logic [127:0] w_data, w_r_data;
  logic [3:0] t_req, t_gnt, t_wen, t_rvalid;
  logic [127:0] t_add, t_data, t_rdata;
  logic [15:0] t_be;

  int checks = 0;
  int errors = 0;
  int due_q [MP][$];
  logic [31:0] adr_q [MP][$];
  logic [127:0] exp_q [$];
  int inflight [MP];
  int last_due [MP];
  int saw_block;

  neureka_tcdm_split_realign #(.BW(BW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .w_req_i(w_req), .w_gnt_o(w_gnt), .w_add_i(w_add), .w_wen_i(w_wen),
    .w_be_i(w_be), .w_data_i(w_data), .w_r_data_o(w_r_data), .w_r_valid_o(w_r_valid),
    .tcdm_req_o(t_req), .tcdm_gnt_i(t_gnt), .tcdm_add_o(t_add), .tcdm_wen_o(t_wen),
    .tcdm_be_o(t_be), .tcdm_data_o(t_data), .tcdm_r_data_i(t_rdata),
    .tcdm_r_valid_i(t_rvalid), .err_o(err)
  );

  always #5 clk = ~clk;

  // Interconnect read data is a fixed function of the word address.
  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [127:0] wide_of(input logic [31:0] a);
    logic [127:0] r;
    for (int p = 0; p < MP; p++) r[32*p+:32] = rd_of(a + 32'(4 * p));
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    w_req = 1'b0; w_wen = 1'b1; w_add = '0; w_be = '0; w_data = '0;
    t_gnt = '0; t_rvalid = '0; t_rdata = '0; clear = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (w_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b expected 0", w_gnt); end
    checks++; if (w_r_valid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", w_r_valid); end
    checks++; if (t_req !== 4'h0) begin errors++; $display("FAIL reset_req: got %b expected 0000", t_req); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (w_r_data !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", w_r_data); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_read_basic();
    logic [127:0] exp_d;
    w_req = 1'b1; w_wen = 1'b1; w_add = 32'h1000; w_be = '1; t_gnt = 4'hF;
    @(negedge clk);
    checks++; if (w_gnt !== 1'b1) begin errors++; $display("FAIL basic_gnt: got %b expected 1", w_gnt); end
    checks++; if (t_req !== 4'hF) begin errors++; $display("FAIL basic_req: got %b expected 1111", t_req); end
    checks++;
    if (t_add !== {32'h100C, 32'h1008, 32'h1004, 32'h1000}) begin
      errors++; $display("FAIL basic_addr: got %h expected 0000100c000010080000100400001000", t_add);
    end
    step();
    idle_inputs();
    exp_d = wide_of(32'h1000);
    t_rdata = exp_d; t_rvalid = 4'hF;
    @(negedge clk);
    checks++; if (w_r_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", w_r_valid); end
    step();
    t_rvalid = '0; t_rdata = '0;
    @(negedge clk);
    checks++; if (w_r_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", w_r_valid); end
    checks++; if (w_r_data !== exp_d) begin errors++; $display("FAIL basic_data: got %h expected %h", w_r_data, exp_d); end
    step();
    @(negedge clk);
    checks++; if (w_r_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b expected 0", w_r_valid); end
    step();
  endtask

  task automatic test_partial_grant();
    logic [3:0] gnt_seq [4];
    logic [3:0] req_exp [4];
    logic [127:0] exp_d;
    gnt_seq[0] = 4'b0011; gnt_seq[1] = 4'b0100; gnt_seq[2] = 4'b0000; gnt_seq[3] = 4'b1000;
    req_exp[0] = 4'b1111; req_exp[1] = 4'b1100; req_exp[2] = 4'b1000; req_exp[3] = 4'b1000;
    w_req = 1'b1; w_wen = 1'b1; w_add = 32'h0000_2340; w_be = '1;
    for (int c = 0; c < 4; c++) begin
      t_gnt = gnt_seq[c];
      @(negedge clk);
      checks++;
      if (t_req !== req_exp[c]) begin errors++; $display("FAIL partial_req c%0d: got %b expected %b", c, t_req, req_exp[c]); end
      checks++;
      if (w_gnt !== (c == 3)) begin errors++; $display("FAIL partial_gnt c%0d: got %b expected %b", c, w_gnt, (c == 3)); end
      step();
    end
    idle_inputs();
    exp_d = wide_of(32'h0000_2340);
    t_rdata = exp_d; t_rvalid = 4'hF;
    @(negedge clk);
    checks++; if (w_r_valid !== 1'b0) begin errors++; $display("FAIL partial_valid_c4: got %b expected 0", w_r_valid); end
    step();
    t_rvalid = '0;
    @(negedge clk);
    checks++; if (w_r_valid !== 1'b1) begin errors++; $display("FAIL partial_valid_c5: got %b expected 1", w_r_valid); end
    checks++; if (w_r_data !== exp_d) begin errors++; $display("FAIL partial_data: got %h expected %h", w_r_data, exp_d); end
    step();
  endtask

  task automatic test_wrap();
    w_req = 1'b1; w_wen = 1'b1; w_add = 32'hFFFF_FFF8; w_be = '1; t_gnt = 4'hF;
    @(negedge clk);
    checks++;
    if (t_add !== {32'h0000_0004, 32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFF8}) begin
      errors++; $display("FAIL wrap_addr: got %h expected 0000000400000000fffffffcfffffff8", t_add);
    end
    step();
    idle_inputs();
    t_rdata = wide_of(32'hFFFF_FFF8); t_rvalid = 4'hF;
    step();
    t_rvalid = '0;
    @(negedge clk);
    checks++;
    if (w_r_data !== wide_of(32'hFFFF_FFF8)) begin errors++; $display("FAIL wrap_data: got %h expected %h", w_r_data, wide_of(32'hFFFF_FFF8)); end
    step();
  endtask

  task automatic test_stray();
    logic [127:0] exp_d;
    idle_inputs();
    t_rvalid = 4'b0010; t_rdata = {4{$urandom}};
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL stray_err_early: got %b expected 0", err); end
    step();
    t_rvalid = '0;
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL stray_err: got %b expected 1", err); end
    checks++; if (w_r_valid !== 1'b0) begin errors++; $display("FAIL stray_valid: got %b expected 0", w_r_valid); end
    step();
    w_req = 1'b1; w_wen = 1'b1; w_add = 32'h0000_3000; w_be = '1; t_gnt = 4'hF;
    step();
    idle_inputs();
    exp_d = wide_of(32'h0000_3000);
    t_rdata = exp_d; t_rvalid = 4'hF;
    step();
    t_rvalid = '0;
    @(negedge clk);
    checks++; if (w_r_valid !== 1'b1) begin errors++; $display("FAIL stray_after_valid: got %b expected 1", w_r_valid); end
    checks++; if (w_r_data !== exp_d) begin errors++; $display("FAIL stray_after_data: got %h expected %h", w_r_data, exp_d); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL stray_sticky: got %b expected 1", err); end
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL stray_clear: got %b expected 0", err); end
    step();
  endtask

  task automatic test_be_write();
    logic [127:0] wd;
    wd = {$urandom, $urandom, $urandom, $urandom};
    w_req = 1'b1; w_wen = 1'b0; w_add = 32'h0000_4000; w_be = 16'hF00F; w_data = wd; t_gnt = 4'b1001;
    @(negedge clk);
    checks++; if (t_wen !== 4'h0) begin errors++; $display("FAIL be_wen: got %b expected 0000", t_wen); end
    checks++; if (t_be !== 16'hF00F) begin errors++; $display("FAIL be_slice: got %h expected f00f", t_be); end
    checks++; if (t_data !== wd) begin errors++; $display("FAIL be_data: got %h expected %h", t_data, wd); end
`ifdef NEUREKA_TCDM_SPLIT_BE_SKIP_EN
    checks++; if (t_req !== 4'b1001) begin errors++; $display("FAIL be_req: got %b expected 1001", t_req); end
    checks++; if (w_gnt !== 1'b1) begin errors++; $display("FAIL be_gnt: got %b expected 1", w_gnt); end
    step();
    w_be = 16'h0000; t_gnt = 4'h0;
    @(negedge clk);
    checks++; if (t_req !== 4'h0) begin errors++; $display("FAIL be0_req: got %b expected 0000", t_req); end
    checks++; if (w_gnt !== 1'b1) begin errors++; $display("FAIL be0_gnt: got %b expected 1", w_gnt); end
    step();
`else
    checks++; if (t_req !== 4'hF) begin errors++; $display("FAIL be_req: got %b expected 1111", t_req); end
    checks++; if (w_gnt !== 1'b0) begin errors++; $display("FAIL be_gnt_early: got %b expected 0", w_gnt); end
    step();
    t_gnt = 4'b0110;
    @(negedge clk);
    checks++; if (t_req !== 4'b0110) begin errors++; $display("FAIL be_req2: got %b expected 0110", t_req); end
    checks++; if (w_gnt !== 1'b1) begin errors++; $display("FAIL be_gnt: got %b expected 1", w_gnt); end
    step();
    w_be = 16'h0000; t_gnt = 4'h0;
    @(negedge clk);
    checks++; if (t_req !== 4'hF) begin errors++; $display("FAIL be0_req: got %b expected 1111", t_req); end
    checks++; if (w_gnt !== 1'b0) begin errors++; $display("FAIL be0_gnt: got %b expected 0", w_gnt); end
    step();
    t_gnt = 4'hF;
    step();
`endif
    idle_inputs();
    step();
    step();
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL be_err: got %b expected 0", err); end
    checks++; if (w_r_valid !== 1'b0) begin errors++; $display("FAIL be_rvalid: got %b expected 0", w_r_valid); end
    step();
  endtask

  // Random or fixed-grant read traffic; the model tracks beats in flight per port.
  task automatic run_traffic(input int n_req, input bit rnd, input int p3_delay, input int max_cyc);
    int issued, got, cyc, d;
    bit active, exp_g, exp_r;
    logic [3:0] gm, gnow;
    logic [31:0] cur;
    logic [127:0] ew;
    issued = 0; got = 0; cyc = 0; active = 1'b0; gm = '0; cur = '0; saw_block = 0;
    for (int p = 0; p < MP; p++) begin
      due_q[p].delete(); adr_q[p].delete(); inflight[p] = 0; last_due[p] = 0;
    end
    exp_q.delete();
    idle_inputs();
    while (got < n_req && cyc < max_cyc) begin
      if (!active && issued < n_req && (!rnd || $urandom_range(0, 2) != 0)) begin
        active = 1'b1; gm = '0;
        cur = $urandom & 32'hFFFF_FFFC;
        w_req = 1'b1; w_wen = 1'b1; w_add = cur; w_be = '1;
      end
      t_gnt = rnd ? 4'($urandom) : 4'hF;
      t_rvalid = '0;
      for (int p = 0; p < MP; p++) begin
        if (due_q[p].size() != 0 && due_q[p][0] <= cyc) begin
          t_rvalid[p] = 1'b1;
          t_rdata[32*p+:32] = rd_of(adr_q[p].pop_front());
          void'(due_q[p].pop_front());
        end
      end
      @(negedge clk);
      gnow = t_req & t_gnt;
      for (int p = 0; p < MP; p++) begin
        exp_r = active && !gm[p] && (inflight[p] < DEPTH);
        checks++;
        if (t_req[p] !== exp_r) begin errors++; $display("FAIL traffic_req p%0d cyc%0d: got %b expected %b", p, cyc, t_req[p], exp_r); end
        if (t_req[p]) begin
          checks++;
          if (t_add[32*p+:32] !== cur + 32'(4 * p)) begin
            errors++; $display("FAIL traffic_addr p%0d: got %h expected %h", p, t_add[32*p+:32], cur + 32'(4 * p));
          end
        end
      end
      if (active && !gm[3] && !t_req[3]) saw_block++;
      exp_g = active && ((gm | gnow) == 4'hF);
      checks++;
      if (w_gnt !== exp_g) begin errors++; $display("FAIL traffic_gnt cyc%0d: got %b expected %b", cyc, w_gnt, exp_g); end
      for (int p = 0; p < MP; p++) begin
        if (gnow[p]) begin
          inflight[p]++;
          d = cyc + 1 + ((p == 3) ? p3_delay : (rnd ? $urandom_range(0, 3) : 0));
          if (d < last_due[p]) d = last_due[p];
          last_due[p] = d;
          due_q[p].push_back(d);
          adr_q[p].push_back(cur + 32'(4 * p));
        end
      end
      gm = gm | gnow;
      if (exp_g) begin
        exp_q.push_back(wide_of(cur));
        active = 1'b0; issued++;
      end
      if (w_r_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL traffic_unexpected cyc%0d: got valid expected none", cyc);
        end else begin
          ew = exp_q.pop_front();
          if (w_r_data !== ew) begin errors++; $display("FAIL traffic_data #%0d: got %h expected %h", got, w_r_data, ew); end
        end
        got++;
        for (int p = 0; p < MP; p++) inflight[p]--;
      end
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL traffic_err cyc%0d: got %b expected 0", cyc, err); end
      step();
      cyc++;
      if (!active) w_req = 1'b0;
    end
    checks++;
    if (got != n_req) begin errors++; $display("FAIL traffic_timeout: got %0d responses expected %0d", got, n_req); end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    run_traffic(3, 1'b0, 4, 200);
    checks++;
    if (saw_block == 0) begin errors++; $display("FAIL b2b_credit_block: got %0d blocked cycles expected >0", saw_block); end
  endtask

  task automatic test_random();
    run_traffic(60, 1'b1, 0, 5000);
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_partial_grant();
    test_wrap();
    test_stray();
    test_be_write();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
